// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Handshake bundle between the 5-stage pipeline and its hazard
//               controller. The pipeline (master) supplies the decode, execute
//               and memory status fields. The controller (slave) returns the
//               stall, flush and hold enables and its performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // pipeline status presented to the controller
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_br_taken;
  logic             ex_md_start;
  logic             imem_ready;
  logic             dmem_busy;

  // controls returned to the pipeline
  logic             pc_write;
  logic             if_write;
  logic             if_flush;
  logic             id_bubble;
  logic             ex_hold;
  logic             mem_hold;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_br_taken, ex_md_start, imem_ready, dmem_busy,
    input  pc_write, if_write, if_flush, id_bubble, ex_hold, mem_hold,
           md_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_br_taken, ex_md_start, imem_ready, dmem_busy,
    output pc_write, if_write, if_flush, id_bubble, ex_hold, mem_hold,
           md_done, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage core.
//               - Load-use stalls and bubble insertion.
//               - Taken-branch squash.
//               - Multi-cycle mult/div freeze.
//               - Data-memory wait freeze.
//               - Instruction-memory miss NOP fill.
//               - Saturating stall and flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  // The first hold cycle is spent in RUN, where the start is seen. Loading
  // MD_LAT-1 therefore yields MD_LAT hold cycles before the done cycle.
  localparam logic [7:0]       c_md_load = 8'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_md_cnt;
  logic [7:0]       w_md_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu;
  logic w_md_active;
  logic w_flush_evt;
  logic w_pc_write;
  logic w_if_write;
  logic w_if_flush;
  logic w_id_bubble;
  logic w_ex_hold;
  logic w_mem_hold;
  logic w_md_done;

  // A load in EX whose destination feeds a register that ID actually reads.
  assign w_lu = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                 (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

  // Mult/div holds EX from the start cycle until the countdown expires.
  assign w_md_active = ((r_state == ST_MD_BUSY) && (r_md_cnt != 8'd0)) ||
                       ((r_state == ST_RUN) && hz.ex_md_start);

  // A branch counts only when no memory wait or mult/div freeze overrides it.
  assign w_flush_evt = hz.ex_br_taken && !hz.dmem_busy && !w_md_active;

  // Next-state logic and prioritised pipeline controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_pc_write   = 1'b1;
    w_if_write   = 1'b1;
    w_if_flush   = 1'b0;
    w_id_bubble  = 1'b0;
    w_ex_hold    = 1'b0;
    w_mem_hold   = 1'b0;
    w_md_done    = 1'b0;

    // The sequencer only advances while the data memory is not stalling.
    if (!hz.dmem_busy) begin
      case (r_state)
        ST_RUN: begin
          if (hz.ex_md_start) begin
            w_state_nxt  = ST_MD_BUSY;
            w_md_cnt_nxt = c_md_load;
          end
        end
        ST_MD_BUSY: begin
          if (r_md_cnt != 8'd0) begin
            w_md_cnt_nxt = r_md_cnt - 8'd1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end

    // While reset is asserted, the pipeline sees the default controls.
    if (!rst) begin
      if (hz.dmem_busy) begin
        w_pc_write = 1'b0;
        w_if_write = 1'b0;
        w_ex_hold  = 1'b1;
        w_mem_hold = 1'b1;
      end else if (w_md_active) begin
        w_pc_write = 1'b0;
        w_if_write = 1'b0;
        w_ex_hold  = 1'b1;
      end else begin
        // The countdown has expired and the result is available this cycle.
        w_md_done = (r_state == ST_MD_BUSY);
        if (hz.ex_br_taken) begin
          w_if_flush  = 1'b1;
          w_id_bubble = 1'b1;
        end else if (w_lu) begin
          w_pc_write  = 1'b0;
          w_if_write  = 1'b0;
          w_id_bubble = 1'b1;
        end else if (!hz.imem_ready) begin
          w_pc_write = 1'b0;
          w_if_flush = 1'b1;
        end
      end
    end
  end

  // FSM state and mult/div countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_md_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_evt && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_write  = w_pc_write;
  assign hz.if_write  = w_if_write;
  assign hz.if_flush  = w_if_flush;
  assign hz.id_bubble = w_id_bubble;
  assign hz.ex_hold   = w_ex_hold;
  assign hz.mem_hold  = w_mem_hold;
  assign hz.md_done   = w_md_done;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios and
//               random traffic are compared against a cycle-level reference
//               model built from the hazard priority rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: outstanding mult/div and hold cycles spent on it
  bit m_pending;
  int m_holds;
  int m_stall;
  int m_flush;

  // DUT outputs sampled at the most recent check
  bit obs_pc, obs_hold, obs_done, obs_memh;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic quiet();
    hz.id_rs       = 5'd0;
    hz.id_rt       = 5'd0;
    hz.id_uses_rs  = 1'b0;
    hz.id_uses_rt  = 1'b0;
    hz.ex_memread  = 1'b0;
    hz.ex_rt       = 5'd0;
    hz.ex_br_taken = 1'b0;
    hz.ex_md_start = 1'b0;
    hz.imem_ready  = 1'b1;
    hz.dmem_busy   = 1'b0;
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_holds   = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // Inputs are set by the caller after posedge. Outputs are checked mid low phase.
  task automatic cycle();
    bit lu, md_hold;
    bit e_pc, e_ifw, e_ifl, e_bub, e_exh, e_memh, e_done;
    @(negedge clk);
    #2;
    lu = hz.ex_memread && (hz.ex_rt != 0) &&
         ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
          (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
    md_hold = m_pending ? (m_holds < MD_LAT) : hz.ex_md_start;
    e_pc = 1; e_ifw = 1; e_ifl = 0; e_bub = 0; e_exh = 0; e_memh = 0; e_done = 0;
    if (hz.dmem_busy) begin
      e_pc = 0; e_ifw = 0; e_exh = 1; e_memh = 1;
    end else if (md_hold) begin
      e_pc = 0; e_ifw = 0; e_exh = 1;
    end else begin
      e_done = m_pending;
      if (hz.ex_br_taken) begin
        e_ifl = 1; e_bub = 1;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end else if (!hz.imem_ready) begin
        e_pc = 0; e_ifl = 1;
      end
    end
    chk_eq("pc_write",  int'(hz.pc_write),  int'(e_pc));
    chk_eq("if_write",  int'(hz.if_write),  int'(e_ifw));
    chk_eq("if_flush",  int'(hz.if_flush),  int'(e_ifl));
    chk_eq("id_bubble", int'(hz.id_bubble), int'(e_bub));
    chk_eq("ex_hold",   int'(hz.ex_hold),   int'(e_exh));
    chk_eq("mem_hold",  int'(hz.mem_hold),  int'(e_memh));
    chk_eq("md_done",   int'(hz.md_done),   int'(e_done));
    chk_eq("stall_cnt", int'(hz.stall_cnt), m_stall);
    chk_eq("flush_cnt", int'(hz.flush_cnt), m_flush);
    obs_pc   = hz.pc_write;
    obs_hold = hz.ex_hold;
    obs_done = hz.md_done;
    obs_memh = hz.mem_hold;
    // advance the model to the next cycle
    if (!e_pc && m_stall < CNT_MAX) m_stall++;
    if (hz.ex_br_taken && !hz.dmem_busy && !md_hold && m_flush < CNT_MAX) m_flush++;
    if (!hz.dmem_busy) begin
      if (md_hold) begin
        if (!m_pending) begin
          m_pending = 1'b1;
          m_holds   = 1;
        end else begin
          m_holds++;
        end
      end else if (m_pending) begin
        m_pending = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    quiet();
    @(negedge clk);
    #2;
    chk_eq("rst_pc_write", int'(hz.pc_write), 1);
    chk_eq("rst_if_write", int'(hz.if_write), 1);
    chk_eq("rst_ex_hold",  int'(hz.ex_hold),  0);
    chk_eq("rst_stall",    int'(hz.stall_cnt), 0);
    chk_eq("rst_flush",    int'(hz.flush_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int done_at;
  int hold_n;
  int memh_n;

  initial begin
    quiet();
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // load-use stall, then the same pattern against r0
    hz.ex_memread = 1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1;
    cycle();
    chk_eq("lu_stall_pc", int'(obs_pc), 0);
    quiet();
    cycle();
    chk_eq("lu_stall_cnt", int'(hz.stall_cnt), 1);
    hz.ex_memread = 1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0; hz.id_uses_rs = 1;
    cycle();
    quiet();

    // taken branch overrides a simultaneous load-use
    hz.ex_br_taken = 1; hz.ex_memread = 1; hz.ex_rt = 5'd7;
    hz.id_rt = 5'd7; hz.id_uses_rt = 1;
    cycle();
    quiet();
    cycle();
    chk_eq("br_flush_cnt", int'(hz.flush_cnt), 1);
    chk_eq("br_stall_cnt", int'(hz.stall_cnt), 1);

    // mult/div: MD_LAT hold cycles, done pulse MD_LAT cycles after start
    apply_reset();
    done_at = -1; hold_n = 0;
    for (int i = 0; i < 7; i++) begin
      hz.ex_md_start = (i == 0);
      cycle();
      if (obs_hold) hold_n++;
      if (obs_done) done_at = i;
    end
    chk_eq("md_hold_cycles", hold_n, MD_LAT);
    chk_eq("md_done_cycle", done_at, MD_LAT);
    chk_eq("md_stall_cnt", int'(hz.stall_cnt), MD_LAT);

    // mult/div with three data-memory wait cycles in the middle
    apply_reset();
    done_at = -1; memh_n = 0;
    for (int i = 0; i < 10; i++) begin
      hz.ex_md_start = (i == 0);
      hz.dmem_busy   = (i >= 1 && i <= 3);
      cycle();
      if (obs_memh) memh_n++;
      if (obs_done) done_at = i;
    end
    chk_eq("md_dmem_done_cycle", done_at, MD_LAT + 3);
    chk_eq("md_dmem_memhold", memh_n, 3);
    quiet();

    // instruction miss for two cycles, taken branch in the second
    hz.imem_ready = 0;
    cycle();
    hz.ex_br_taken = 1;
    cycle();
    chk_eq("imem_br_pc", int'(obs_pc), 1);
    quiet();

    // asynchronous reset in the middle of a mult/div
    hz.ex_md_start = 1;
    cycle();
    hz.ex_md_start = 0;
    cycle();
    #1;
    rst = 1'b1;
    #1;
    chk_eq("arst_ex_hold", int'(hz.ex_hold), 0);
    chk_eq("arst_md_done", int'(hz.md_done), 0);
    chk_eq("arst_stall",   int'(hz.stall_cnt), 0);
    chk_eq("arst_flush",   int'(hz.flush_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      chk_eq("arst_no_done", int'(hz.md_done), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();

    // stall counter saturation
    hz.ex_memread = 1; hz.ex_rt = 5'd1; hz.id_rs = 5'd1; hz.id_uses_rs = 1;
    for (int i = 0; i < CNT_MAX + 5; i++) cycle();
    chk_eq("stall_sat", int'(hz.stall_cnt), CNT_MAX);
    quiet();

    // random traffic with periodic resets
    for (int n = 0; n < 2500; n++) begin
      if (n % 250 == 0) apply_reset();
      hz.id_rs       = 5'($urandom_range(0, 3));
      hz.id_rt       = 5'($urandom_range(0, 3));
      hz.id_uses_rs  = 1'($urandom_range(0, 1));
      hz.id_uses_rt  = 1'($urandom_range(0, 1));
      hz.ex_memread  = 1'($urandom_range(0, 1));
      hz.ex_rt       = 5'($urandom_range(0, 3));
      hz.ex_br_taken = ($urandom_range(0, 5) == 0);
      hz.ex_md_start = ($urandom_range(0, 9) == 0);
      hz.imem_ready  = ($urandom_range(0, 5) != 0);
      hz.dmem_busy   = ($urandom_range(0, 6) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
